imem_prog_loader: RTL
=====================

// Module: imem_prog_loader
// PURPOSE
//   Upstream of the CPU core: receives the program as a stream of 5-bit quintets and
//   assembles 15-bit instruction words. Writes them into the 8-entry instruction RAM
//   and verifies a trailing XOR checksum. Raises cpu_en only after a clean load.
//   Replaces the inline counter loader in the top-level wrapper; adds handshake + check.
// PARAMETERS
//   QW          5   quintet width (bits per transfer)
//   QPW         3   quintets per instruction word (word width = QW*QPW = 15)
//   ADDR_WIDTH  3   instruction RAM address width (2**ADDR_WIDTH words)
//   CHECKSUM_EN 1   1: expect a checksum quintet after the last word; 0: no check
// PORTS
//   clk         in   1          system clock
//   rst         in   1          synchronous, active-high reset
//   in_valid    in   1          quintet on in_data is valid
//   in_data     in   QW         program quintet
//   in_ready    out  1          loader can accept a quintet this cycle
//   imem_wr     out  1          instruction RAM write strobe (one-cycle pulse)
//   imem_waddr  out  ADDR_WIDTH instruction RAM write address
//   imem_wdata  out  QW*QPW     instruction RAM write data
//   cpu_en      out  1          program loaded and verified; CPU may run
//   load_err    out  1          checksum mismatch; sticky until rst
//   busy        out  1          load in progress (S_LOAD/S_WRITE/S_CHECK)
// BEHAVIOUR
//   Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
//   Handshake: a transfer occurs on a rising clk edge where in_valid & in_ready.
//     in_data is sampled only on a transfer. in_valid may drop between quintets.
//   States: S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERR. All outputs are registered.
//   Reset: state=S_LOAD, q_cnt=0, word_addr=0, csum=0, shift reg=0.
//     After reset: imem_wr=0, imem_waddr=0, imem_wdata=0, cpu_en=0, load_err=0, busy=1.
//     Reset mid-load abandons the partial word and restarts at address 0.
//     RAM contents already written are not cleared by this block.
//   S_LOAD: in_ready=1.
//     On each transfer: csum ^= in_data; quintet k (k=q_cnt) goes to bits [QW*k +: QW].
//     Transfers are ordered LSB quintet first. q_cnt increments on each transfer.
//     On the QPW-th transfer: q_cnt wraps to 0 and the state moves to S_WRITE.
//   S_WRITE: exactly one cycle; in_ready=0.
//     imem_wr=1, imem_waddr=word_addr, imem_wdata=assembled word.
//     Next state, by word_addr:
//       below the last address: word_addr+1, back to S_LOAD.
//       last address: S_CHECK if CHECKSUM_EN=1, else S_DONE.
//     Latency: the last quintet is accepted at edge N; imem_wr is high for the cycle
//       after edge N. The next quintet can be accepted at edge N+2 at the earliest.
//   S_CHECK: in_ready=1. On a transfer, in_data is compared with csum (the XOR of all
//     QPW*2**ADDR_WIDTH program quintets). Equal -> S_DONE; unequal -> S_ERR.
//   S_DONE: cpu_en=1 from the edge of entry; in_ready=0, busy=0.
//     in_valid is ignored; no further imem_wr. The state holds until rst.
//   S_ERR: load_err=1, cpu_en=0, in_ready=0, busy=0. The state holds until rst.
//   imem_wr is 0 in every state except S_WRITE.
//   word_addr never wraps during a load: completing the last address terminates loading.
// TESTING
//   T1 rst, then 8 words; word0 = quintets 0x15,0x12,0x1A.
//      -> imem_wr at addr 0 with data 0x6A55, and at addrs 1..7 in order.
//      -> correct checksum quintet -> cpu_en=1 on the next edge, load_err=0.
//   T2 same stream, checksum XOR 0x01 -> load_err=1, cpu_en stays 0, in_ready=0.
//   T3 in_valid held high continuously across S_WRITE cycles, plus random 0-3 cycle gaps
//      -> exactly 8 writes; data matches the model; no quintet dropped or duplicated.
//   T4 rst asserted after 10 quintets, then a full clean stream -> first write is addr 0.
//      -> the 10 aborted quintets do not affect the checksum; cpu_en=1 at the end.
//   T5 after cpu_en=1, drive in_valid=1 for 20 cycles -> imem_wr stays 0.
//      -> cpu_en stays 1 and in_ready stays 0.
//   T6 CHECKSUM_EN=0, 24 quintets -> cpu_en=1 on the edge after the 8th imem_wr.
//      -> any 25th quintet is not accepted (in_ready=0).

Source files
------------

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: assembles quintet stream into instruction words, writes imem, verifies XOR checksum
module imem_prog_loader #(
    parameter int QW          = 5,
    parameter int QPW         = 3,
    parameter int ADDR_WIDTH  = 3,
    parameter int CHECKSUM_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [QW-1:0]         in_data,
    output logic                  in_ready,
    output logic                  imem_wr,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [QW*QPW-1:0]     imem_wdata,
    output logic                  cpu_en,
    output logic                  load_err,
    output logic                  busy
);
    localparam int CW = $clog2(QPW + 1);
    typedef enum logic [2:0] {S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERR} state_t;
    state_t state, state_nx;
    logic [CW-1:0] q_cnt;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [QW-1:0] csum;
    logic [QW*QPW-1:0] sreg;
    logic xfer, last_q, last_a;
    assign xfer   = in_valid & in_ready;
    assign last_q = q_cnt == CW'(QPW - 1);
    assign last_a = word_addr == '1;
    // Outputs decode directly from registered state, so none depend on inputs
    assign in_ready   = state == S_LOAD || state == S_CHECK;
    assign imem_wr    = state == S_WRITE;
    assign imem_waddr = word_addr;
    assign imem_wdata = sreg;
    assign cpu_en     = state == S_DONE;
    assign load_err   = state == S_ERR;
    assign busy       = state == S_LOAD || state == S_WRITE || state == S_CHECK;
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  state_nx = (xfer && last_q) ? S_WRITE : S_LOAD;
            S_WRITE: state_nx = !last_a ? S_LOAD : (CHECKSUM_EN != 0) ? S_CHECK : S_DONE;
            S_CHECK: state_nx = !xfer ? S_CHECK : (in_data == csum) ? S_DONE : S_ERR;
            default: state_nx = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            q_cnt     <= '0;
            word_addr <= '0;
            csum      <= '0;
            sreg      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_LOAD && xfer) begin
                csum                <= csum ^ in_data;
                sreg[QW*q_cnt +: QW] <= in_data;
                q_cnt               <= last_q ? '0 : q_cnt + CW'(1);
            end
            if (state == S_WRITE && !last_a)
                word_addr <= word_addr + ADDR_WIDTH'(1);
        end
    end
endmodule
